// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM states, mode encodings and signed clamp helper for addsub_serial
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest operand the clamp helper can describe; callers truncate to their own width.
  localparam int SAT_MAX_W = 256;

  // Max positive (neg=0) or min negative (neg=1) two's-complement value of 'width' bits.
  function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic neg);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_W; i++) begin
      if (i < width) begin
        v[i] = (i == width - 1) ? neg : ~neg;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-wide adder slice with carry out and carry into its top bit
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign sum  = full[DIGIT-1:0];
  assign cout = full[DIGIT];
  // The top sum bit is x^y^carry_in, so the carry into it falls out without a second adder.
  assign cmsb = full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement add/sub with valid/ready handshakes
// Optional macro ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             k,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("addsub_serial: DIGIT must divide WIDTH");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] x_dig;
  logic [DIGIT-1:0] y_dig;
  logic [DIGIT-1:0] sum_dig;
  logic             c_dig;
  logic             cmsb_dig;
  logic             last_dig;

  assign x_dig    = a_q[int'(cnt)*DIGIT +: DIGIT];
  assign y_dig    = b_q[int'(cnt)*DIGIT +: DIGIT];
  assign last_dig = (cnt == CW'(NDIG - 1));

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (x_dig),
    .y    (y_dig),
    .cin  (carry),
    .sum  (sum_dig),
    .cout (c_dig),
    .cmsb (cmsb_dig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert B once here and seed the carry with the mode.
            a_q   <= a;
            b_q   <= b ^ {WIDTH{k == MODE_SUB}};
            carry <= (k == MODE_SUB);
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s_q[int'(cnt)*DIGIT +: DIGIT] <= sum_dig;
          carry <= c_dig;
          if (last_dig) begin
            cout_q      <= c_dig;
            ovf_q       <= cmsb_dig ^ c_dig;
`ifdef ADDSUB_SAT_EN
            if (cmsb_dig ^ c_dig) begin
              s_q <= WIDTH'(sat_value(WIDTH, a_q[WIDTH-1]));
            end
`endif
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial two's-complement adder/subtractor; successor to the 4-bit ripple add/sub.
- Processes DIGIT bits per clock through one digit-wide adder slice with a registered carry, so area stays flat as WIDTH grows.
- Valid/ready handshakes on input and output; reports unsigned carry/borrow and signed overflow.
- Used wherever a wide add/sub can trade latency for area.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle; must divide WIDTH (elaboration error otherwise).
- NDIG, WIDTH/DIGIT, derived local constant: number of digit cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept an operation.
- k  in  1  mode: 0 = a+b, 1 = a-b.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- cout  out  1  carry out of MSB. For subtraction, 1 = no borrow (a >= b unsigned).
- ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; s = 0, cout = 0, ovf = 0, out_valid = 0; digit counter and carry = 0.
  - in_ready = 1 because state is IDLE, but in_valid is ignored while rst_n is low.
- in_ready = (state == IDLE), combinational from state only.
- FSM states IDLE, RUN, DONE:
  - IDLE: on in_valid & in_ready at edge E0, latch a, (b XOR {WIDTH{k}}), carry = k, cnt = 0; go to RUN.
  - RUN: each edge adds digit cnt of the latched a and b plus carry into the slice, writes s[cnt*DIGIT +: DIGIT], and updates carry.
    - At cnt == NDIG-1, also record the carry into the MSB, set cout and ovf, and go to DONE. Otherwise cnt increments.
  - DONE: out_valid = 1; s, cout and ovf are held stable. On out_valid & out_ready, go to IDLE (out_valid drops next cycle).
- Latency: digits are computed on edges E1..E_NDIG; out_valid is visible after E_NDIG.
  - Earliest output handshake is E_NDIG+1; earliest next accept is E_NDIG+2.
  - Peak throughput is one operation per NDIG+2 cycles.
- Operands are captured at acceptance; a, b and k changes afterwards have no effect.
- in_valid during RUN or DONE is ignored (in_ready = 0). No queuing.
- s is undefined-but-deterministic during RUN (partial digits visible). Consumers sample only when out_valid = 1.
- NDIG == 1 is legal: one RUN cycle.
- Wrap-around: the result is modulo 2^WIDTH unless the optional feature is enabled.
- Reset mid-RUN or mid-DONE aborts the operation immediately; no result is emitted and all outputs take their reset values.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: on signed overflow, s is clamped. If latched a[WIDTH-1] == 0, s = 0111…1 (max positive); otherwise s = 1000…0 (min negative).
  - The clamp is applied at the DONE transition. ovf and cout still report the raw result.
- Undefined: s is the wrapped result and no clamp logic is present.

Decomposition:
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - mode constants MODE_ADD = 0, MODE_SUB = 1;
  - a function computing the signed clamp value for a given width.
- One sub-module, addsub_digit: combinational DIGIT-wide adder slice with inputs x, y, cin and outputs sum, cout, and carry into its top bit (the latter needed for ovf).

Test Plan (WIDTH=16, DIGIT=4):
- k=0, a=0x1234, b=0x0FFF, accepted at E0 -> out_valid after E4, s=0x2233, cout=0, ovf=0.
- k=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0 (borrow), ovf=0.
- k=0, a=0x7FFF, b=0x0001 -> ovf=1, cout=0, s=0x8000. With ADDSUB_SAT_EN, s=0x7FFF.
- k=1, a=0x8000, b=0x0001 -> ovf=1, cout=1, s=0x7FFF. With ADDSUB_SAT_EN, s=0x8000.
- Backpressure: out_ready=0 for 5 cycles, with a second in_valid held throughout -> out_valid, s, cout and ovf stay stable and in_ready=0. After the output handshake the second operation is accepted and gives its correct result.
- Reset asserted after 2 RUN cycles -> out_valid=0, s=0, in_ready=1 immediately. A following operation 0x00FF + 0x0001 gives s=0x0100, cout=0, ovf=0.
